tristate_bus_arbiter: RTL and testbench

Round-robin arbiter that shares one tri-state bus among `NUM_REQ` drivers built from our tri-state storage cells. It produces one-hot, registered driver enables and inserts a guaranteed all-off turnaround gap between owners, so two `notif1` drivers never fight on the bus. It also bounds ownership with a hold limit and sits between requesting agents and the bus driver enables.

---
 rtl/tristate_bus_arbiter.sv | 147 ++++++++++++++
 tb/tb_tristate_bus_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/tristate_bus_arbiter.sv
// Round-robin arbiter for a shared tri-state bus: registered one-hot driver
// enables, bounded ownership, and an all-off turnaround gap between owners.
module tristate_bus_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned MAX_HOLD  = 8,
  parameter int unsigned TA_CYCLES = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] gnt_id,
  output logic                       gnt_vld,
  output logic                       timeout
);

  localparam int unsigned IDW = $clog2(NUM_REQ);
  localparam int unsigned HW  = $clog2(MAX_HOLD + 1);
  localparam int unsigned TW  = $clog2(TA_CYCLES + 1);
  localparam logic [HW-1:0]  HOLD_MAX = HW'(MAX_HOLD);
  localparam logic [TW-1:0]  TA_MAX   = TW'(TA_CYCLES);
  localparam logic [IDW-1:0] LAST_ID  = IDW'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_e;

  state_e               state_q, state_d;
  logic [IDW-1:0]       ptr_q, ptr_d;
  logic [IDW-1:0]       owner_q, owner_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic [TW-1:0]        ta_q, ta_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0]       gnt_id_q, gnt_id_d;
  logic                 gnt_vld_q, gnt_vld_d;
  logic                 timeout_q, timeout_d;

  logic                 win_vld;
  logic [IDW-1:0]       win_id;
  logic [IDW-1:0]       cand;
  logic [NUM_REQ-1:0]   owner_oh;
  logic                 others;
  logic                 release_now;

  // First requester at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    cand    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = IDW'((32'(ptr_q) + i) % NUM_REQ);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_id  = cand;
      end
    end
  end

  assign owner_oh = NUM_REQ'(1) << owner_q;
  assign others   = |(req & ~owner_oh);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    hold_d      = hold_q;
    ta_d        = ta_q;
    timeout_d   = 1'b0;
    release_now = 1'b0;

    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = GRANT;
          owner_d = win_id;
          hold_d  = HW'(1);
        end
      end
      GRANT: begin
        if (!req[owner_q]) begin
          release_now = 1'b1;
        end else if (hold_q == HOLD_MAX) begin
          if (others) begin
            release_now = 1'b1;
            timeout_d   = 1'b1;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
        if (release_now) begin
          state_d = TURN;
          ptr_d   = (owner_q == LAST_ID) ? '0 : owner_q + 1'b1;
          ta_d    = TW'(1);
          hold_d  = '0;
        end
      end
      TURN: begin
        if (ta_q < TA_MAX) begin
          ta_d = ta_q + 1'b1;
        end else begin
          ta_d = '0;
          if (win_vld) begin
            state_d = GRANT;
            owner_d = win_id;
            hold_d  = HW'(1);
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are derived from the next state so they register alongside it.
    gnt_vld_d = (state_d == GRANT);
    gnt_d     = gnt_vld_d ? (NUM_REQ'(1) << owner_d) : '0;
    gnt_id_d  = gnt_vld_d ? owner_d : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      hold_q    <= '0;
      ta_q      <= '0;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      gnt_vld_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      hold_q    <= hold_d;
      ta_q      <= ta_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      gnt_vld_q <= gnt_vld_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign gnt_vld = gnt_vld_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Directed bench for tristate_bus_arbiter with defaults (4 requesters,
// hold limit 8, one turnaround cycle); expected values are hand-derived.
module tb_tristate_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_vld;
  logic       timeout;

  int n_chk  = 0;
  int n_pass = 0;
  logic mon_en = 1'b0;

  tristate_bus_arbiter #(
    .NUM_REQ  (4),
    .MAX_HOLD (8),
    .TA_CYCLES(1)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .gnt_vld(gnt_vld),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Bus-safety invariant: never more than one enable, valid tracks enables.
  always @(negedge clk) begin
    if (mon_en) begin
      n_chk++;
      if ($countones(gnt) > 1 || gnt_vld !== (|gnt))
        $display("FAIL onehot_inv: gnt=%b gnt_vld=%b, required zero/one-hot with vld=|gnt", gnt, gnt_vld);
      else n_pass++;
    end
  end

  task automatic do_reset;
    rst_n = 1'b0;
    req   = 4'b0000;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req   = 4'b1111;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_chk++;
      if ({gnt, gnt_vld, gnt_id, timeout} !== 8'b0)
        $display("FAIL reset c%0d: gnt=%b vld=%b id=%0d to=%b, required all zero", c, gnt, gnt_vld, gnt_id, timeout);
      else n_pass++;
    end
    mon_en = 1'b1;
    req    = 4'b0000;
    rst_n  = 1'b1;
    tick();
    n_chk++;
    if (gnt !== 4'b0000) $display("FAIL reset_idle: gnt=%b required 0000", gnt);
    else n_pass++;
  endtask

  task automatic test_single;
    req = 4'b0001;
    for (int c = 1; c <= 3; c++) begin
      tick();
      n_chk++;
      if (gnt !== 4'b0001 || gnt_id !== 2'd0 || gnt_vld !== 1'b1)
        $display("FAIL single_gnt c%0d: gnt=%b id=%0d vld=%b, required 0001/0/1", c, gnt, gnt_id, gnt_vld);
      else n_pass++;
    end
    req = 4'b0000;
    tick();
    n_chk++;
    if (gnt !== 4'b0000 || timeout !== 1'b0)
      $display("FAIL single_release: gnt=%b to=%b, required 0000/0", gnt, timeout);
    else n_pass++;
    req = 4'b0010;
    tick();
    n_chk++;
    if (gnt !== 4'b0010 || gnt_id !== 2'd1)
      $display("FAIL single_regrant: gnt=%b id=%0d, required 0010/1", gnt, gnt_id);
    else n_pass++;
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_rotation;
    logic [3:0] exp_g;
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      for (int c = 0; c < 8; c++) begin
        tick();
        n_chk++;
        if (gnt !== exp_g || timeout !== 1'b0 || gnt_id !== 2'(k % 4))
          $display("FAIL rot_hold k%0d c%0d: gnt=%b to=%b id=%0d, required %b/0/%0d", k, c, gnt, timeout, gnt_id, exp_g, k % 4);
        else n_pass++;
      end
      if (k < 4) begin
        tick();
        n_chk++;
        if (gnt !== 4'b0000 || timeout !== 1'b1)
          $display("FAIL rot_gap k%0d: gnt=%b to=%b, required 0000/1", k, gnt, timeout);
        else n_pass++;
      end
    end
    req = 4'b0000;
    tick();
    n_chk++;
    if (gnt !== 4'b0000 || timeout !== 1'b0)
      $display("FAIL rot_voluntary: gnt=%b to=%b, required 0000/0", gnt, timeout);
    else n_pass++;
    tick();
  endtask

  task automatic test_lone_holder;
    do_reset();
    req = 4'b0100;
    for (int c = 0; c < 20; c++) begin
      tick();
      n_chk++;
      if (gnt !== 4'b0100 || timeout !== 1'b0 || gnt_id !== 2'd2)
        $display("FAIL lone_hold c%0d: gnt=%b to=%b id=%0d, required 0100/0/2", c, gnt, timeout, gnt_id);
      else n_pass++;
    end
    req = 4'b0101;
    tick();
    n_chk++;
    if (gnt !== 4'b0000 || timeout !== 1'b1)
      $display("FAIL lone_force: gnt=%b to=%b, required 0000/1", gnt, timeout);
    else n_pass++;
    tick();
    n_chk++;
    if (gnt !== 4'b0001 || timeout !== 1'b0 || gnt_id !== 2'd0)
      $display("FAIL lone_next: gnt=%b to=%b id=%0d, required 0001/0/0", gnt, timeout, gnt_id);
    else n_pass++;
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_simultaneous;
    do_reset();
    req = 4'b0010;
    tick();
    tick();
    n_chk++;
    if (gnt !== 4'b0010) $display("FAIL simul_own: gnt=%b required 0010", gnt);
    else n_pass++;
    req = 4'b1001;
    tick();
    n_chk++;
    if (gnt !== 4'b0000 || timeout !== 1'b0)
      $display("FAIL simul_gap: gnt=%b to=%b, required 0000/0", gnt, timeout);
    else n_pass++;
    tick();
    n_chk++;
    if (gnt !== 4'b1000 || gnt_id !== 2'd3)
      $display("FAIL simul_win: gnt=%b id=%0d, required 1000/3", gnt, gnt_id);
    else n_pass++;
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_reset_mid_grant;
    // Leave ptr at 2 so a missing pointer reset would pick requester 3.
    req = 4'b0010;
    tick();
    req = 4'b0000;
    tick();
    tick();
    req = 4'b1000;
    for (int c = 1; c <= 4; c++) begin
      tick();
      n_chk++;
      if (gnt !== 4'b1000)
        $display("FAIL midrst_own c%0d: gnt=%b required 1000", c, gnt);
      else n_pass++;
    end
    rst_n = 1'b0;
    req   = 4'b1010;
    tick();
    n_chk++;
    if ({gnt, gnt_vld, gnt_id, timeout} !== 8'b0)
      $display("FAIL midrst_off: gnt=%b vld=%b id=%0d to=%b, required all zero", gnt, gnt_vld, gnt_id, timeout);
    else n_pass++;
    rst_n = 1'b1;
    tick();
    n_chk++;
    if (gnt !== 4'b0010 || gnt_id !== 2'd1 || gnt_vld !== 1'b1)
      $display("FAIL midrst_regrant: gnt=%b id=%0d vld=%b, required 0010/1/1", gnt, gnt_id, gnt_vld);
    else n_pass++;
    req = 4'b0000;
    tick();
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    test_reset();
    test_single();
    test_rotation();
    test_lone_holder();
    test_simultaneous();
    test_reset_mid_grant();
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
